// File: rtl/cpu_selftest_ctrl_if.sv
// Spare synchronous memory read port used by the self-test controller.
// The controller is the master of this port. The memory is the slave.
interface cpu_selftest_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   // mem_rd_en is a single-cycle strobe that carries mem_rd_addr. There is no
   // ready signal. mem_rd_data must hold the addressed word in the cycle that
   // follows the strobe, and the master samples it at the end of that cycle.
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;

   modport master (output mem_rd_en, output mem_rd_addr, input mem_rd_data);
   modport slave  (input mem_rd_en, input mem_rd_addr, output mem_rd_data);
endinterface

// File: rtl/cpu_selftest_ctrl.sv
// On-chip CPU self-test: reset, run until HALT, check the final PC and the memory slots, then report.
// Optional feature macro SELFTEST_TIMEOUT_EN: when it is defined, a saturated RUN cycle count ends the run with fail_code 3.
module cpu_selftest_ctrl #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16,
   parameter int PC_W      = 9,
   parameter int NCHECK    = 4,
   parameter int RST_CYC   = 2,
   parameter int TIMEOUT_W = 20,
   localparam int FI_W     = (NCHECK > 1) ? $clog2(NCHECK) : 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     halt,
   input  logic [PC_W-1:0]          pc,
   input  logic [PC_W-1:0]          exp_pc,
   input  logic [NCHECK-1:0]        chk_en,
   input  logic [NCHECK*ADDR_W-1:0] chk_addr,
   input  logic [NCHECK*DATA_W-1:0] chk_data,
   cpu_selftest_ctrl_if.master      mem,
   output logic                     cpu_reset_n,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [1:0]               fail_code,
   output logic [FI_W-1:0]          fail_idx,
   output logic [DATA_W-1:0]        got_data,
   output logic [TIMEOUT_W-1:0]     cycles,
   output logic [2:0]               dbg_state
);

   localparam int IDX_W = $clog2(NCHECK + 1);
   localparam int RC_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NCHECK);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RST   = 3'd1,
      S_RUN   = 3'd2,
      S_PCCHK = 3'd3,
      S_SCAN  = 3'd4,
      S_CMP   = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t                state, state_n;
   logic [RC_W-1:0]       rst_cnt, rst_cnt_n;
   logic                  first, first_n;
   logic [IDX_W-1:0]      idx, idx_n;
   logic [TIMEOUT_W-1:0]  cycles_n;
   logic                  pass_n;
   logic [1:0]            fail_code_n;
   logic [FI_W-1:0]       fail_idx_n;
   logic [DATA_W-1:0]     got_data_n;
   logic                  rd_en;
   logic [ADDR_W-1:0]     rd_addr;
   logic [FI_W-1:0]       slot;

   assign slot            = idx[FI_W-1:0];
   assign mem.mem_rd_en   = rd_en;
   assign mem.mem_rd_addr = rd_addr;
   assign dbg_state       = state;

   always_comb begin
      state_n     = state;
      rst_cnt_n   = rst_cnt;
      first_n     = first;
      idx_n       = idx;
      cycles_n    = cycles;
      pass_n      = pass;
      fail_code_n = fail_code;
      fail_idx_n  = fail_idx;
      got_data_n  = got_data;
      rd_en       = 1'b0;
      rd_addr     = '0;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               pass_n      = 1'b0;
               fail_code_n = 2'd0;
               fail_idx_n  = '0;
               got_data_n  = '0;
               cycles_n    = '0;
               rst_cnt_n   = '0;
               state_n     = S_RST;
            end
         end
         S_RST: begin
            if (rst_cnt == RST_LAST) begin
               first_n = 1'b1;
               state_n = S_RUN;
            end else begin
               rst_cnt_n = rst_cnt + 1'b1;
            end
         end
         S_RUN: begin
            // The first RUN cycle masks a HALT level left over from before the reset.
            first_n  = 1'b0;
            cycles_n = (&cycles) ? cycles : cycles + 1'b1;
            if (!first && halt) begin
               state_n = S_PCCHK;
            end
`ifdef SELFTEST_TIMEOUT_EN
            else if (&cycles_n) begin
               fail_code_n = 2'd3;
               state_n     = S_DONE;
            end
`endif
         end
         S_PCCHK: begin
            if (pc != exp_pc) begin
               fail_code_n = 2'd1;
               state_n     = S_DONE;
            end else begin
               idx_n   = '0;
               state_n = S_SCAN;
            end
         end
         S_SCAN: begin
            if (idx == IDX_END) begin
               pass_n  = 1'b1;
               state_n = S_DONE;
            end else if (chk_en[slot]) begin
               rd_en   = 1'b1;
               rd_addr = chk_addr[slot*ADDR_W +: ADDR_W];
               state_n = S_CMP;
            end else begin
               idx_n = idx + 1'b1;
            end
         end
         S_CMP: begin
            if (mem.mem_rd_data != chk_data[slot*DATA_W +: DATA_W]) begin
               fail_code_n = 2'd2;
               fail_idx_n  = slot;
               got_data_n  = mem.mem_rd_data;
               state_n     = S_DONE;
            end else begin
               idx_n   = idx + 1'b1;
               state_n = S_SCAN;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         rst_cnt     <= '0;
         first       <= 1'b0;
         idx         <= '0;
         cycles      <= '0;
         pass        <= 1'b0;
         fail_code   <= 2'd0;
         fail_idx    <= '0;
         got_data    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cpu_reset_n <= 1'b0;
      end else begin
         state       <= state_n;
         rst_cnt     <= rst_cnt_n;
         first       <= first_n;
         idx         <= idx_n;
         cycles      <= cycles_n;
         pass        <= pass_n;
         fail_code   <= fail_code_n;
         fail_idx    <= fail_idx_n;
         got_data    <= got_data_n;
         // Status flags are decoded from the next state so they change together with the state.
         busy        <= state_n inside {S_RST, S_RUN, S_PCCHK, S_SCAN, S_CMP};
         done        <= (state_n == S_DONE);
         cpu_reset_n <= !(state_n inside {S_IDLE, S_RST});
      end
   end

endmodule
